l2_arbiter: RTL and testbench

//  Two-master arbiter directly upstream of the L2 cache controller. Merges the L1 I-cache and L1 D-cache

---
 rtl/l2_arbiter.sv | 120 ++++++++++++
 tb/tb_l2_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// Two-master (I-cache / D-cache) round-robin arbiter in front of the L2 port.
// One transaction in flight, forced IDLE bubble after each, sticky watchdog flag.
module l2_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stb,
  input  logic              i_cyc,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  output logic              i_retry,
  input  logic              d_stb,
  input  logic              d_cyc,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              d_retry,
  output logic              l2_stb,
  output logic              l2_cyc,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  input  logic              l2_retry,
  output logic              timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t          state_reg;
  logic            last_d_reg;   // 1 when D was the most recent grant
  logic [WD_W-1:0] wdog_reg;
  logic [WD_W-1:0] wdog_next;
  logic            timeout_err_reg;

  logic req_i, req_d, gnt_i, gnt_d, pick_d, gnt_cyc;

  assign req_i = i_stb & i_cyc;
  assign req_d = d_stb & d_cyc;
  // Grant-side outputs are forced quiet during reset, even mid-transaction.
  assign gnt_i = (state_reg == GNT_I) & ~rst;
  assign gnt_d = (state_reg == GNT_D) & ~rst;
  assign pick_d = req_d & (~req_i | ~last_d_reg);
  assign gnt_cyc = (state_reg == GNT_I) ? i_cyc : d_cyc;
  assign wdog_next = (wdog_reg == WD_MAX) ? wdog_reg : wdog_reg + WD_W'(1);

  always_comb begin
    l2_stb   = (gnt_i & req_i) | (gnt_d & req_d);
    l2_cyc   = (gnt_i & i_cyc) | (gnt_d & d_cyc);
    l2_write = 1'b0;
    l2_addr  = '0;
    l2_wdata = '0;
    if (gnt_i) begin
      l2_write = i_write;
      l2_addr  = i_addr;
      l2_wdata = i_wdata;
    end else if (gnt_d) begin
      l2_write = d_write;
      l2_addr  = d_addr;
      l2_wdata = d_wdata;
    end
    // An aborted master (cyc low) never receives a completion.
    i_resp  = gnt_i & i_cyc & l2_resp;
    d_resp  = gnt_d & d_cyc & l2_resp;
    i_rdata = i_resp ? l2_rdata : '0;
    d_rdata = d_resp ? l2_rdata : '0;
    i_retry = ~rst & req_i & ~i_resp;
    d_retry = ~rst & req_d & ~d_resp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      last_d_reg      <= 1'b0;
      wdog_reg        <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_i | req_d) begin
            state_reg  <= pick_d ? GNT_D : GNT_I;
            last_d_reg <= pick_d;
            wdog_reg   <= '0;
          end
        end
        GNT_I, GNT_D: begin
          if (l2_resp) begin
            state_reg <= IDLE;
          end else begin
            wdog_reg <= wdog_next;
            if (wdog_next == WD_MAX)
              timeout_err_reg <= 1'b1;
          end
          if (!gnt_cyc)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign timeout_err = timeout_err_reg;

  // l2_retry is informational only; the arbiter keeps waiting regardless.
  logic unused_retry;
  assign unused_retry = l2_retry;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: per-cycle vector table plus hand-written
// long-wait, watchdog and reset-during-grant sequences.
module tb_l2_arbiter;

  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 64;
  localparam int TIMEOUT = 16;

  localparam logic [ADDR_W-1:0] I_ADDR = 32'h0000_0400;
  localparam logic [ADDR_W-1:0] D_ADDR = 32'h0000_1000;
  localparam logic [ADDR_W-1:0] W_ADDR = 32'h0000_2000;
  localparam logic [LINE_W-1:0] I_WD   = 64'h1111_2222_3333_4444;
  localparam logic [LINE_W-1:0] D_WD   = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [LINE_W-1:0] RD     = 64'hDEAD_BEEF_0123_4567;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_stb, i_cyc, i_write;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_wdata, i_rdata;
  logic              i_resp, i_retry;
  logic              d_stb, d_cyc, d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata, d_rdata;
  logic              d_resp, d_retry;
  logic              l2_stb, l2_cyc, l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata, l2_rdata;
  logic              l2_resp, l2_retry;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_stb(i_stb), .i_cyc(i_cyc), .i_write(i_write), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_rdata(i_rdata), .i_resp(i_resp), .i_retry(i_retry),
    .d_stb(d_stb), .d_cyc(d_cyc), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp), .d_retry(d_retry),
    .l2_stb(l2_stb), .l2_cyc(l2_cyc), .l2_write(l2_write), .l2_addr(l2_addr),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .l2_retry(l2_retry), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One record per clock cycle: inputs for the cycle, expected outputs mid-cycle.
  typedef struct {
    bit       rst, is, ic, ds, dc, resp;
    bit       e_stb, e_cyc;
    bit [1:0] e_gnt;   // 0 none, 1 I, 2 D
    bit       e_ir, e_dr, e_iry, e_dry;
  } vec_t;

  vec_t tbl[25];
  int   d_pulses;

  initial begin
    rst = 1'b1; l2_resp = 1'b0; l2_retry = 1'b0; l2_rdata = RD;
    i_stb = 0; i_cyc = 0; i_write = 0; i_addr = I_ADDR; i_wdata = I_WD;
    d_stb = 0; d_cyc = 0; d_write = 0; d_addr = D_ADDR; d_wdata = D_WD;

    //           rst is ic ds dc rsp  stb cyc gnt ir dr iry dry
    tbl[0]  = '{1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 1};  // D read, arbitration cycle
    tbl[2]  = '{0, 0, 0, 1, 1, 1,   1, 1, 2, 0, 1, 0, 0};  // granted, L2 hits at once
    tbl[3]  = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 1, 1, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0};  // retry quiet under reset
    tbl[5]  = '{0, 1, 1, 1, 1, 0,   0, 0, 0, 0, 0, 1, 1};  // tie after reset
    tbl[6]  = '{0, 1, 1, 1, 1, 1,   1, 1, 2, 0, 1, 1, 0};  // D wins first
    tbl[7]  = '{0, 1, 1, 1, 1, 0,   0, 0, 0, 0, 0, 1, 1};
    tbl[8]  = '{0, 1, 1, 1, 1, 1,   1, 1, 1, 1, 0, 0, 1};  // then I
    tbl[9]  = '{0, 1, 1, 1, 1, 0,   0, 0, 0, 0, 0, 1, 1};
    tbl[10] = '{0, 1, 1, 1, 1, 1,   1, 1, 2, 0, 1, 1, 0};  // then D
    tbl[11] = '{0, 1, 1, 1, 1, 0,   0, 0, 0, 0, 0, 1, 1};
    tbl[12] = '{0, 1, 1, 1, 1, 1,   1, 1, 1, 1, 0, 0, 1};  // then I
    tbl[13] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 1};
    tbl[15] = '{0, 0, 0, 1, 1, 0,   1, 1, 2, 0, 0, 0, 1};  // waiting on L2
    tbl[16] = '{0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0};  // abort: cyc dropped
    tbl[17] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
    tbl[18] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
    tbl[19] = '{0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0};  // late L2 resp dropped
    tbl[20] = '{0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 1};
    tbl[21] = '{0, 1, 1, 1, 1, 1,   1, 1, 2, 0, 1, 1, 0};  // resp + new I request
    tbl[22] = '{0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0};  // I waits through bubble
    tbl[23] = '{0, 1, 1, 0, 0, 1,   1, 1, 1, 1, 0, 0, 0};
    tbl[24] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};

    for (int r = 0; r < 25; r++) begin
      @(posedge clk); #1;
      rst = tbl[r].rst; i_stb = tbl[r].is; i_cyc = tbl[r].ic;
      d_stb = tbl[r].ds; d_cyc = tbl[r].dc; l2_resp = tbl[r].resp;
      @(negedge clk);
      $display("vec %0d: l2_stb=%b l2_cyc=%b i_resp=%b d_resp=%b i_retry=%b d_retry=%b",
               r, l2_stb, l2_cyc, i_resp, d_resp, i_retry, d_retry);
      chk($sformatf("v%0d l2_stb", r), 64'(l2_stb), 64'(tbl[r].e_stb));
      chk($sformatf("v%0d l2_cyc", r), 64'(l2_cyc), 64'(tbl[r].e_cyc));
      chk($sformatf("v%0d i_resp", r), 64'(i_resp), 64'(tbl[r].e_ir));
      chk($sformatf("v%0d d_resp", r), 64'(d_resp), 64'(tbl[r].e_dr));
      chk($sformatf("v%0d i_retry", r), 64'(i_retry), 64'(tbl[r].e_iry));
      chk($sformatf("v%0d d_retry", r), 64'(d_retry), 64'(tbl[r].e_dry));
      chk($sformatf("v%0d i_rdata", r), i_rdata, tbl[r].e_ir ? RD : 64'h0);
      chk($sformatf("v%0d d_rdata", r), d_rdata, tbl[r].e_dr ? RD : 64'h0);
      chk($sformatf("v%0d timeout_err", r), 64'(timeout_err), 64'h0);
      if (tbl[r].e_gnt != 2'd0) begin
        chk($sformatf("v%0d l2_addr", r), 64'(l2_addr),
            64'((tbl[r].e_gnt == 2'd1) ? I_ADDR : D_ADDR));
        chk($sformatf("v%0d l2_wdata", r), l2_wdata, (tbl[r].e_gnt == 2'd1) ? I_WD : D_WD);
      end
    end

    // D write with a 40-cycle L2 delay while I waits; watchdog trips on the way.
    @(posedge clk); #1;
    d_stb = 1; d_cyc = 1; d_write = 1; d_addr = W_ADDR; i_stb = 1; i_cyc = 1; l2_resp = 0;
    @(negedge clk);
    chk("wr arb l2_stb", 64'(l2_stb), 64'h0);
    d_pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      $display("wr wait %0d: l2_stb=%b l2_write=%b d_retry=%b i_retry=%b timeout_err=%b",
               k, l2_stb, l2_write, d_retry, i_retry, timeout_err);
      if (d_resp) d_pulses++;
      chk($sformatf("wr%0d l2_stb", k), 64'(l2_stb), 64'h1);
      chk($sformatf("wr%0d l2_write", k), 64'(l2_write), 64'h1);
      chk($sformatf("wr%0d l2_addr", k), 64'(l2_addr), 64'(W_ADDR));
      chk($sformatf("wr%0d d_retry", k), 64'(d_retry), 64'h1);
      chk($sformatf("wr%0d i_retry", k), 64'(i_retry), 64'h1);
      chk($sformatf("wr%0d timeout_err", k), 64'(timeout_err), (k >= 17) ? 64'h1 : 64'h0);
    end
    @(posedge clk); #1;
    l2_resp = 1;
    @(negedge clk);
    $display("wr done: d_resp=%b d_rdata=%h i_resp=%b", d_resp, d_rdata, i_resp);
    if (d_resp) d_pulses++;
    chk("wr d_rdata", d_rdata, RD);
    chk("wr i_resp", 64'(i_resp), 64'h0);
    @(posedge clk); #1;
    l2_resp = 0; d_stb = 0; d_cyc = 0; d_write = 0;
    @(negedge clk);
    if (d_resp) d_pulses++;
    chk("wr d_resp pulses", 64'(d_pulses), 64'h1);
    chk("wr bubble l2_stb", 64'(l2_stb), 64'h0);
    chk("wr bubble i_retry", 64'(i_retry), 64'h1);
    @(posedge clk); #1;
    l2_resp = 1;
    @(negedge clk);
    $display("i after write: i_resp=%b l2_addr=%h", i_resp, l2_addr);
    chk("i after write i_resp", 64'(i_resp), 64'h1);
    chk("i after write l2_addr", 64'(l2_addr), 64'(I_ADDR));
    @(posedge clk); #1;
    l2_resp = 0; i_stb = 0; i_cyc = 0;

    // Reset clears the sticky flag; then a never-answered D request.
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("rst terr still set", 64'(timeout_err), 64'h1);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst terr cleared", 64'(timeout_err), 64'h0);
    @(posedge clk); #1;
    d_stb = 1; d_cyc = 1; d_addr = D_ADDR;
    @(negedge clk);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      $display("wdog %0d: l2_stb=%b timeout_err=%b", k, l2_stb, timeout_err);
      chk($sformatf("wd%0d l2_stb", k), 64'(l2_stb), 64'h1);
      chk($sformatf("wd%0d timeout_err", k), 64'(timeout_err), (k == 17) ? 64'h1 : 64'h0);
    end
    @(posedge clk); #1;
    rst = 1; l2_resp = 1;
    @(negedge clk);
    $display("rst mid-grant: l2_stb=%b d_resp=%b d_retry=%b", l2_stb, d_resp, d_retry);
    chk("rstgnt l2_stb", 64'(l2_stb), 64'h0);
    chk("rstgnt l2_cyc", 64'(l2_cyc), 64'h0);
    chk("rstgnt d_resp", 64'(d_resp), 64'h0);
    chk("rstgnt d_retry", 64'(d_retry), 64'h0);
    @(posedge clk); #1;
    rst = 0; l2_resp = 0;
    @(negedge clk);
    $display("after rst: l2_stb=%b timeout_err=%b", l2_stb, timeout_err);
    chk("postrst l2_stb", 64'(l2_stb), 64'h0);
    chk("postrst timeout_err", 64'(timeout_err), 64'h0);
    chk("postrst d_retry", 64'(d_retry), 64'h1);
    @(posedge clk); #1;
    d_stb = 0; d_cyc = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
